// File: rtl/lfu_word_pipe_if.sv
// Handshake bundle for the word-wide blitter logic function unit.
// The master side feeds source/destination words and accepts results; the slave side is the pipe.
interface lfu_word_pipe_if #(
  parameter int WIDTH = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] SRCD;
  logic [WIDTH-1:0] DSTD;
  logic [3:0]       LFUC;
  logic             CMPEN;
  logic [WIDTH-1:0] CMPD;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] DOUT;
  logic             INHIBIT;
  logic             ZERO;

  modport master (
    output IN_VALID, SRCD, DSTD, LFUC, CMPEN, CMPD, OUT_READY,
    input  IN_READY, OUT_VALID, DOUT, INHIBIT, ZERO
  );

  modport slave (
    input  IN_VALID, SRCD, DSTD, LFUC, CMPEN, CMPD, OUT_READY,
    output IN_READY, OUT_VALID, DOUT, INHIBIT, ZERO
  );
endinterface

// File: rtl/lfu_word_pipe.sv
// Word-wide blitter LFU: per-bit minterm function of S and D, two-stage valid/ready pipe,
// optional compare-inhibit against a pattern, zero flag and a saturating write counter.
module lfu_cell (
  input  logic       s,
  input  logic       d,
  input  logic [3:0] f,
  output logic       r
);
  assign r = (~s & ~d & f[0]) | (~s & d & f[1]) | (s & ~d & f[2]) | (s & d & f[3]);
endmodule

module lfu_word_pipe #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  lfu_word_pipe_if.slave  bus,
  input  logic            CLRCNT,
  output logic [CNTW-1:0] WCOUNT
);
  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             cmpen;
    logic [WIDTH-1:0] cmpd;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] dout;
    logic             inhibit;
    logic             zero;
  } s2_t;

  logic [WIDTH-1:0] r0;
  s1_t              s1;
  s2_t              s2;
  logic [2:1]       vld_pipe;
  logic             adv2, in_ready, in_xfer, out_xfer;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    lfu_cell u_cell (
      .s (bus.SRCD[i]),
      .d (bus.DSTD[i]),
      .f (bus.LFUC),
      .r (r0[i])
    );
  end

  // Stage 2 frees up when it is empty or draining this cycle; stage 1 then follows.
  assign adv2     = vld_pipe[1] & (~vld_pipe[2] | bus.OUT_READY);
  assign in_ready = ~vld_pipe[1] | adv2;
  assign in_xfer  = bus.IN_VALID & in_ready;
  assign out_xfer = vld_pipe[2] & bus.OUT_READY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (in_xfer)
        s1 <= '{r: r0, cmpen: bus.CMPEN, cmpd: bus.CMPD};
      if (adv2)
        s2 <= '{dout: s1.r, inhibit: s1.cmpen & (s1.r == s1.cmpd), zero: (s1.r == '0)};
      vld_pipe[1] <= in_xfer | (vld_pipe[1] & ~adv2);
      vld_pipe[2] <= adv2 | (vld_pipe[2] & ~bus.OUT_READY);
    end
  end

  // Clear beats a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      WCOUNT <= '0;
    else if (CLRCNT)
      WCOUNT <= '0;
    else if (out_xfer & ~s2.inhibit & ~&WCOUNT)
      WCOUNT <= WCOUNT + 1'b1;
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = vld_pipe[2];
  assign bus.DOUT      = s2.dout;
  assign bus.INHIBIT   = s2.inhibit;
  assign bus.ZERO      = s2.zero;

  logic [2:0] inflight;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) inflight <= '0;
    else       inflight <= inflight + 3'(in_xfer) - 3'(out_xfer);
  end

  a_stall_stable: assert property (@(posedge CLK) disable iff (RESET)
    bus.OUT_VALID && !bus.OUT_READY |=>
      $stable(bus.DOUT) && $stable(bus.INHIBIT) && $stable(bus.ZERO) && bus.OUT_VALID);

  a_inflight: assert property (@(posedge CLK) disable iff (RESET)
    inflight <= 3'd2 && inflight == 3'(vld_pipe[1]) + 3'(vld_pipe[2]));
endmodule
